// File: rtl/tanh4_rr_scheduler.sv
// tanh4_rr_scheduler
// Shares one combinational 4-bit approximate tanh core among NREQ requesters.
// A round-robin arbiter picks one requester per cycle. The accepted operand
// then passes through two registered stages (S1 holds the operand, S2 holds
// the result). Valid/ready backpressure runs through both stages, and every
// result carries the index of the requester it came from.
//
// Optional feature: define TANH4_STATS_EN to add the saturating statistics
// counters o_stat_done and o_stat_stall.
//
// Ports:
//   i_clk         clock, all state updates on the rising edge
//   i_rst         synchronous active-high reset
//   i_req_valid   [NREQ]    per-requester operand valid
//   i_req_data    [4*NREQ]  operand of requester i at bits [4i+3:4i]
//   o_req_ready   [NREQ]    per-requester accept, one-hot or zero
//   o_rsp_valid             result valid
//   o_rsp_data    [4]       tanh core output
//   o_rsp_id      [IDW]     originating requester index
//   i_rsp_ready             consumer accept
//   o_stat_done   [16]      (TANH4_STATS_EN) results handed to the consumer
//   o_stat_stall  [16]      (TANH4_STATS_EN) cycles a valid result waited
module tanh4_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [4*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_rsp_valid,
  output logic [3:0]        o_rsp_data,
  output logic [IDW-1:0]    o_rsp_id,
  input  logic              i_rsp_ready
`ifdef TANH4_STATS_EN
  ,
  output logic [15:0]       o_stat_done,
  output logic [15:0]       o_stat_stall
`endif
);

  // Approximate tanh lookup. Output bits [1:0] always equal input bit 0.
  function automatic logic [3:0] tanh4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'd0:    y = 4'd0;
      4'd1:    y = 4'd3;
      4'd2:    y = 4'd12;
      4'd3:    y = 4'd3;
      4'd4:    y = 4'd8;
      4'd5:    y = 4'd3;
      4'd6:    y = 4'd12;
      4'd7:    y = 4'd7;
      4'd8:    y = 4'd0;
      4'd9:    y = 4'd3;
      4'd10:   y = 4'd12;
      4'd11:   y = 4'd11;
      4'd12:   y = 4'd4;
      4'd13:   y = 4'd3;
      4'd14:   y = 4'd12;
      default: y = 4'd15;
    endcase
    return y;
  endfunction

  logic              r_s1_valid;
  logic [3:0]        r_s1_data;
  logic [IDW-1:0]    r_s1_id;
  logic              r_s2_valid;
  logic [3:0]        r_s2_data;
  logic [IDW-1:0]    r_s2_id;
  logic [IDW-1:0]    r_ptr;

  logic              w_adv;
  logic              w_s1_load;
  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_grant_id;
  logic              w_grant_any;
  logic [3:0]        w_sel_data;
  logic              w_hs;

  // S2 moves whenever it is empty or the consumer takes it; S1 can refill
  // whenever it is empty or S2 is moving.
  assign w_adv     = !r_s2_valid || i_rsp_ready;
  assign w_s1_load = !r_s1_valid || w_adv;

  // Round-robin search starting just after the last granted index, wrapping.
  // The outer loop walks priority order; the inner loop maps the rotated
  // position back to a fixed requester index so every select stays constant.
  always_comb begin
    w_grant     = '0;
    w_grant_id  = '0;
    w_grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_grant_any && (j == ((int'(r_ptr) + k) % NREQ)) && i_req_valid[j]) begin
          w_grant_any = 1'b1;
          w_grant[j]  = 1'b1;
          w_grant_id  = IDW'(j);
        end
      end
    end
  end

  // Operand of the granted requester.
  always_comb begin
    w_sel_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_grant[j]) begin
        w_sel_data = i_req_data[4*j +: 4];
      end
    end
  end

  // Ready is withheld during reset so nothing is accepted while the pipeline
  // is being flushed.
  assign o_req_ready = (w_s1_load && !i_rst) ? w_grant : '0;
  assign w_hs        = w_grant_any && w_s1_load && !i_rst;

  // Pipeline and arbiter pointer. The pointer resets to NREQ-1 so that
  // requester 0 is first in line after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_id    <= '0;
      r_ptr      <= IDW'(NREQ - 1);
    end else begin
      if (w_hs) begin
        r_ptr <= w_grant_id;
      end
      if (w_adv) begin
        r_s2_valid <= r_s1_valid;
        r_s2_data  <= tanh4(r_s1_data);
        r_s2_id    <= r_s1_id;
      end
      if (w_s1_load) begin
        if (w_hs) begin
          r_s1_valid <= 1'b1;
          r_s1_data  <= w_sel_data;
          r_s1_id    <= w_grant_id;
        end else begin
          r_s1_valid <= 1'b0;
          r_s1_data  <= '0;
          r_s1_id    <= '0;
        end
      end
    end
  end

  assign o_rsp_valid = r_s2_valid;
  assign o_rsp_data  = r_s2_data;
  assign o_rsp_id    = r_s2_id;

`ifdef TANH4_STATS_EN
  logic [15:0] r_stat_done;
  logic [15:0] r_stat_stall;

  // Saturating counters of delivered results and of stalled result cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_done  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (r_s2_valid && i_rsp_ready && (r_stat_done != 16'hFFFF)) begin
        r_stat_done <= r_stat_done + 16'd1;
      end
      if (r_s2_valid && !i_rsp_ready && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign o_stat_done  = r_stat_done;
  assign o_stat_stall = r_stat_stall;
`endif

endmodule
